// File: rtl/vga_timing_device_pkg.sv
// Shared constants for the programmable video timing generator:
// register indices, mode bit positions and default 640x480 timing.
package vga_pkg;

  localparam logic [3:0] REG_ID       = 4'd0;
  localparam logic [3:0] REG_TYPE     = 4'd1;
  localparam logic [3:0] REG_MODE     = 4'd2;
  localparam logic [3:0] REG_H_ACTIVE = 4'd3;
  localparam logic [3:0] REG_V_BACK   = 4'd10;
  localparam logic [3:0] REG_FCNT     = 4'd11;
  localparam logic [3:0] REG_STATUS   = 4'd12;
  localparam logic [3:0] REG_LINE     = 4'd13;

  localparam int MODE_EN   = 0;
  localparam int MODE_HPOL = 1;
  localparam int MODE_VPOL = 2;
  localparam int MODE_IRQ  = 3;
  localparam int MODE_REP  = 4;

  localparam logic [5:0] MODE_RESET = 6'h01;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FRONT  = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BACK   = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FRONT  = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BACK   = 33;

endpackage

// File: rtl/vga_timing_device_if.sv
// CPU register bus: control select, write port, read port.
// master = CPU side, slave = timing device side.
interface vga_timing_device_if;

  logic        control;
  logic        write_enable;
  logic [7:0]  write_address;
  logic [15:0] data_in;
  logic        read_enable;
  logic [7:0]  read_address;
  logic [15:0] data_out;

  modport master (
    output control, write_enable, write_address, data_in,
    output read_enable, read_address,
    input  data_out
  );

  modport slave (
    input  control, write_enable, write_address, data_in,
    input  read_enable, read_address,
    output data_out
  );

endinterface

// File: rtl/vga_timing_device_axis_counter.sv
// One timing axis: counter with wrap, sync and active decode.
// Ports: clk/rst, i_clr, i_step, 4 timing fields; o_count/o_wrap/o_sync/o_active.
module vga_axis_counter #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_step,
  input  logic [W-1:0] i_active,
  input  logic [W-1:0] i_front,
  input  logic [W-1:0] i_sync,
  input  logic [W-1:0] i_back,
  output logic [W-1:0] o_count,
  output logic         o_wrap,
  output logic         o_sync,
  output logic         o_active
);

  logic [W-1:0] r_count;
  logic [W+1:0] w_cnt;
  logic [W+1:0] w_next;
  logic [W+1:0] w_total;
  logic [W+1:0] w_lo;
  logic [W+1:0] w_hi;

  assign w_cnt   = {2'b00, r_count};
  assign w_next  = w_cnt + (W+2)'(1);
  assign w_lo    = {2'b00, i_active} + {2'b00, i_front};
  assign w_hi    = w_lo + {2'b00, i_sync};
  assign w_total = w_hi + {2'b00, i_back};

  // total of 0 behaves as 1: every step wraps
  assign o_wrap   = i_step && (w_next >= w_total);
  assign o_sync   = (w_cnt >= w_lo) && (w_cnt < w_hi);
  assign o_active = w_cnt < {2'b00, i_active};
  assign o_count  = r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clr)
      r_count <= '0;
    else if (o_wrap)
      r_count <= '0;
    else if (i_step)
      r_count <= w_next[W-1:0];
  end

endmodule

// File: rtl/vga_timing_device.sv
// Programmable video timing generator with register bus.
// Ports: cpu_clock, reset, pixel_en, bus (slave); sync/active/x/y/frame_start/irq.
module vga_timing_device
  import vga_pkg::*;
#(
  parameter logic [15:0] DEVICE_ID    = 16'h0,
  parameter logic [7:0]  DEVICE_TYPE  = 8'h7,
  parameter int          COORD_WIDTH  = 12,
  parameter int          DEF_H_ACTIVE = VGA_H_ACTIVE,
  parameter int          DEF_H_FRONT  = VGA_H_FRONT,
  parameter int          DEF_H_SYNC   = VGA_H_SYNC,
  parameter int          DEF_H_BACK   = VGA_H_BACK,
  parameter int          DEF_V_ACTIVE = VGA_V_ACTIVE,
  parameter int          DEF_V_FRONT  = VGA_V_FRONT,
  parameter int          DEF_V_SYNC   = VGA_V_SYNC,
  parameter int          DEF_V_BACK   = VGA_V_BACK
) (
  input  logic                   cpu_clock,
  input  logic                   reset,
  input  logic                   pixel_en,
  vga_timing_device_if.slave     bus,
  output logic                   h_sync_signal,
  output logic                   v_sync_signal,
  output logic                   active,
  output logic [COORD_WIDTH-1:0] x,
  output logic [COORD_WIDTH-1:0] y,
  output logic                   frame_start,
  output logic                   irq
);

  localparam int W = COORD_WIDTH;

  // index 0..7 = H act/front/sync/back, V act/front/sync/back
  logic [W-1:0] r_stg [8];
  logic [W-1:0] r_wrk [8];
  logic [W-1:0] w_def [8];
  logic [5:0]   r_mode;
  logic [15:0]  r_fcnt;
  logic         r_vblank;
  logic [15:0]  w_rd;

  logic [3:0] w_widx;
  logic [3:0] w_ridx;
  logic [2:0] w_wsel;
  logic [2:0] w_rsel;
  logic       w_wr;
  logic       w_en;
  logic       w_fs;
  logic       w_vb_set;
  logic       w_load;
  logic       w_act;

  logic [W-1:0] w_h;
  logic [W-1:0] w_v;
  logic         w_h_wrap;
  logic         w_v_wrap;
  logic         w_h_sync;
  logic         w_v_sync;
  logic         w_h_act;
  logic         w_v_act;

  assign w_def[0] = W'(DEF_H_ACTIVE);
  assign w_def[1] = W'(DEF_H_FRONT);
  assign w_def[2] = W'(DEF_H_SYNC);
  assign w_def[3] = W'(DEF_H_BACK);
  assign w_def[4] = W'(DEF_V_ACTIVE);
  assign w_def[5] = W'(DEF_V_FRONT);
  assign w_def[6] = W'(DEF_V_SYNC);
  assign w_def[7] = W'(DEF_V_BACK);

  assign w_widx = bus.write_address[3:0];
  assign w_ridx = bus.read_address[3:0];
  assign w_wsel = 3'(w_widx - REG_H_ACTIVE);
  assign w_rsel = 3'(w_ridx - REG_H_ACTIVE);
  assign w_wr   = bus.control & bus.write_enable;
  assign w_en   = r_mode[MODE_EN];

  assign w_fs     = w_en & pixel_en & (w_h == '0) & (w_v == '0);
  assign w_vb_set = w_en & pixel_en & (w_h == '0) & (w_v == r_wrk[4]);
  // while disabled the working copy tracks staging continuously
  assign w_load   = w_fs | ~w_en;
  assign w_act    = w_en & w_h_act & w_v_act;

  vga_axis_counter #(.W(W)) u_h (
    .clk      (cpu_clock),
    .rst      (reset),
    .i_clr    (~w_en),
    .i_step   (w_en & pixel_en),
    .i_active (r_wrk[0]),
    .i_front  (r_wrk[1]),
    .i_sync   (r_wrk[2]),
    .i_back   (r_wrk[3]),
    .o_count  (w_h),
    .o_wrap   (w_h_wrap),
    .o_sync   (w_h_sync),
    .o_active (w_h_act)
  );

  vga_axis_counter #(.W(W)) u_v (
    .clk      (cpu_clock),
    .rst      (reset),
    .i_clr    (~w_en),
    .i_step   (w_h_wrap),
    .i_active (r_wrk[4]),
    .i_front  (r_wrk[5]),
    .i_sync   (r_wrk[6]),
    .i_back   (r_wrk[7]),
    .o_count  (w_v),
    .o_wrap   (w_v_wrap),
    .o_sync   (w_v_sync),
    .o_active (w_v_act)
  );

  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        r_stg[i] <= w_def[i];
        r_wrk[i] <= w_def[i];
      end
    end else begin
      if (w_wr && w_widx >= REG_H_ACTIVE && w_widx <= REG_V_BACK)
        r_stg[w_wsel] <= bus.data_in[W-1:0];
      if (w_load)
        for (int i = 0; i < 8; i++)
          r_wrk[i] <= r_stg[i];
    end
  end

  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      r_mode   <= MODE_RESET;
      r_fcnt   <= '0;
      r_vblank <= 1'b0;
    end else begin
      if (w_wr && w_widx == REG_MODE)
        r_mode <= bus.data_in[5:0];
      if (w_fs)
        r_fcnt <= r_fcnt + 16'd1;
      // set beats a same-cycle write-1-to-clear
      if (w_vb_set)
        r_vblank <= 1'b1;
      else if (w_wr && w_widx == REG_STATUS && bus.data_in[0])
        r_vblank <= 1'b0;
    end
  end

  always_comb begin
    w_rd = '0;
    unique case (1'b1)
      (w_ridx == REG_ID):     w_rd = DEVICE_ID;
      (w_ridx == REG_TYPE):   w_rd = {8'h13, DEVICE_TYPE};
      (w_ridx == REG_MODE):   w_rd = {10'b0, r_mode};
      (w_ridx >= REG_H_ACTIVE &&
       w_ridx <= REG_V_BACK): w_rd = 16'(r_stg[w_rsel]);
      (w_ridx == REG_FCNT):   w_rd = r_fcnt;
      (w_ridx == REG_STATUS): w_rd = {15'b0, r_vblank};
      (w_ridx == REG_LINE):   w_rd = 16'(w_v);
      default:                w_rd = '0;
    endcase
  end

  always_ff @(posedge cpu_clock) begin
    if (reset)
      bus.data_out <= '0;
    else if (bus.read_enable && bus.control)
      bus.data_out <= w_rd;
  end

  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      h_sync_signal <= 1'b1;
      v_sync_signal <= 1'b1;
      active        <= 1'b0;
      x             <= '0;
      y             <= '0;
      frame_start   <= 1'b0;
    end else begin
      h_sync_signal <= (w_en & w_h_sync) ^ ~r_mode[MODE_HPOL];
      v_sync_signal <= (w_en & w_v_sync) ^ ~r_mode[MODE_VPOL];
      active        <= w_act;
      x             <= w_act ? (w_h >> r_mode[MODE_REP +: 2]) : '0;
      y             <= w_act ? (w_v >> r_mode[MODE_REP +: 2]) : '0;
      frame_start   <= w_fs;
    end
  end

  assign irq = r_vblank & r_mode[MODE_IRQ];

endmodule
